handshake_slave_fifo: RTL and testbench

//  Receive-side partner of the valid/ready master stage. Accepts 32-bit words
//  on the upstream valid/ready port and buffers them in a DEPTH-entry FIFO.

---
 rtl/handshake_slave_fifo.sv | 95 +++++++++
 tb/tb_handshake_slave_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_slave_fifo.sv
// -----------------------------------------------------------------------------
// handshake_slave_fifo
//
// Receive side of a valid/ready link. Upstream words are buffered in a small
// DEPTH-entry FIFO and presented first-word-fall-through on a downstream
// valid/ready port. A wrapping counter records how many upstream beats have
// been accepted since reset.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   valid      upstream word valid
//   data_in    upstream word
//   ready      upstream may transfer this cycle (registered state only)
//   out_valid  downstream word valid (FIFO not empty)
//   out_data   downstream word, head of FIFO; don't-care while out_valid=0
//   out_ready  downstream consumes the head word this cycle
//   level      current occupancy, 0..DEPTH
//   beat_cnt   accepted upstream beats, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module handshake_slave_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         beat_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Full/empty come from the occupancy register, so ready and out_valid
    // have no combinational path from valid or out_ready.
    assign ready     = (level != FULL_LEVEL);
    assign out_valid = (level != '0);

    assign push = valid & ready;
    assign pop  = out_valid & out_ready;

    // First-word-fall-through: the head entry is always on the output.
    assign out_data = mem[rd_ptr];

    // Control state. DEPTH is a power of two, so the pointers wrap from
    // DEPTH-1 to 0 by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register sees the pre-edge values of its neighbours.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Storage. Gated by rst_n so no write lands on a reset edge.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale entries are unreachable
        // because level and the pointers are cleared, and leaving it unreset
        // lets the array map onto plain RAM/register-file cells.
        if (rst_n && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_handshake_slave_fifo.sv
// -----------------------------------------------------------------------------
// tb_handshake_slave_fifo
//
// Self-checking bench. A queue-based reference model tracks the FIFO contents
// and accepted-beat count; each scenario task drives stimulus and compares the
// DUT against that model inline. A second instance built with CNT_W=4 covers
// beat counter wrap-around.
// -----------------------------------------------------------------------------
module tb_handshake_slave_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  beat_cnt;

    // Narrow-counter instance.
    logic              valid4;
    logic [DATA_W-1:0] data_in4;
    logic              ready4;
    logic              out_valid4;
    logic [DATA_W-1:0] out_data4;
    logic              out_ready4;
    logic [LVL_W-1:0]  level4;
    logic [3:0]        beat_cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO contents and total accepted beats.
    logic [DATA_W-1:0] model_q[$];
    int unsigned       model_beats;

    always #5 clk = ~clk;

    handshake_slave_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data_in(data_in),
        .ready(ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .level(level), .beat_cnt(beat_cnt)
    );

    handshake_slave_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid(valid4), .data_in(data_in4),
        .ready(ready4), .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready4), .level(level4), .beat_cnt(beat_cnt4)
    );

    // Apply one cycle of inputs to the main DUT, advance past the edge and
    // update the model from the specification's push/pop rules.
    task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d,
                               input logic r);
        bit do_push;
        bit do_pop;
        valid     = v;
        data_in   = d;
        out_ready = r;
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) begin
            model_q.push_back(d);
            model_beats++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_q.delete();
        model_beats = 0;
    endtask

    task automatic test_reset();
        valid = 0; data_in = '0; out_ready = 0;
        valid4 = 0; data_in4 = '0; out_ready4 = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (ready !== 1'b1 || out_valid !== 1'b0 || level !== '0 || beat_cnt !== '0) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got ready=%b ovalid=%b level=%0d beats=%0d want 1 0 0 0",
                         i, ready, out_valid, level, beat_cnt);
            end
            drive_cycle(1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_fill_full();
        logic [DATA_W-1:0] exp_order[4];
        apply_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'hA0 + i, 1'b0);
        n_cmp++;
        if (ready !== 1'b0 || level !== LVL_W'(4)) begin
            n_bad++;
            $display("FAIL full_after_4 got ready=%b level=%0d want 0 4", ready, level);
        end
        // A fifth word held on valid must not be taken while full.
        for (int i = 0; i < 2; i++) drive_cycle(1'b1, 32'hA4, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(4) || beat_cnt !== CNT_W'(4) || out_data !== 32'hA0) begin
            n_bad++;
            $display("FAIL full_hold got level=%0d beats=%0d head=%h want 4 4 a0",
                     level, beat_cnt, out_data);
        end
        // Single pop pulse with valid still held: no push on the same edge.
        drive_cycle(1'b1, 32'hA4, 1'b1);
        n_cmp++;
        if (ready !== 1'b1 || level !== LVL_W'(3) || out_data !== 32'hA1) begin
            n_bad++;
            $display("FAIL pop_from_full got ready=%b level=%0d head=%h want 1 3 a1",
                     ready, level, out_data);
        end
        drive_cycle(1'b1, 32'hA4, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(4) || beat_cnt !== CNT_W'(5)) begin
            n_bad++;
            $display("FAIL a4_accepted got level=%0d beats=%0d want 4 5", level, beat_cnt);
        end
        exp_order = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_order[i]) begin
                n_bad++;
                $display("FAIL drain_order idx=%0d got v=%b data=%h want 1 %h",
                         i, out_valid, out_data, exp_order[i]);
            end
            drive_cycle(1'b0, '0, 1'b1);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || level !== '0) begin
            n_bad++;
            $display("FAIL drained got ovalid=%b level=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_stream();
        int next_exp = 0;
        int lvl_bad  = 0;
        apply_reset();
        for (int i = 0; i < 104; i++) begin
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (out_data !== DATA_W'(next_exp)) begin
                    n_bad++;
                    $display("FAIL stream_order got %0d want %0d", out_data, next_exp);
                end
                next_exp++;
            end
            if (level > LVL_W'(1)) lvl_bad++;
            drive_cycle(i < 100, DATA_W'(i), 1'b1);
        end
        n_cmp++;
        if (next_exp != 100 || lvl_bad != 0 || beat_cnt !== CNT_W'(100)) begin
            n_bad++;
            $display("FAIL stream_total got recv=%0d lvl_over=%0d beats=%0d want 100 0 100",
                     next_exp, lvl_bad, beat_cnt);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic              hold_v = 0;
        logic [DATA_W-1:0] hold_d = '0;
        logic [DATA_W-1:0] sb[$];
        logic              r;
        apply_reset();
        while (recv < 1000 && cyc < 20000) begin
            // Upstream keeps valid and data stable until the word is taken.
            if (!hold_v && sent < 1000 && $urandom_range(1, 0) == 1) begin
                hold_v = 1;
                hold_d = $urandom;
            end
            r = ($urandom_range(1, 0) == 1);
            n_cmp++;
            if (level !== LVL_W'(model_q.size()) || ready !== (model_q.size() < DEPTH) ||
                out_valid !== (model_q.size() > 0) ||
                (model_q.size() > 0 && out_data !== model_q[0])) begin
                n_bad++;
                $display("FAIL random_state cyc=%0d got level=%0d ready=%b ov=%b data=%h want level=%0d",
                         cyc, level, ready, out_valid, out_data, model_q.size());
            end
            if (r && out_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0 || out_data !== sb[0]) begin
                    n_bad++;
                    $display("FAIL random_sb recv=%0d got %h want %h", recv, out_data,
                             sb.size() ? sb[0] : '0);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                recv++;
            end
            if (hold_v && ready === 1'b1) begin
                sb.push_back(hold_d);
                sent++;
                drive_cycle(1'b1, hold_d, r);
                hold_v = 0;
            end else begin
                drive_cycle(hold_v, hold_d, r);
            end
            cyc++;
        end
        n_cmp++;
        if (recv != 1000 || beat_cnt !== CNT_W'(1000)) begin
            n_bad++;
            $display("FAIL random_total got recv=%0d beats=%0d cyc=%0d want 1000 1000",
                     recv, beat_cnt, cyc);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'hDEAD_0000 + i, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(3)) begin
            n_bad++;
            $display("FAIL pre_reset_level got %0d want 3", level);
        end
        // Reset edge with a pop and a push both requested: neither may complete.
        valid = 1; data_in = 32'hDEAD_00FF; out_ready = 1;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        valid = 0; out_ready = 0;
        model_q.delete();
        model_beats = 0;
        n_cmp++;
        if (level !== '0 || out_valid !== 1'b0 || ready !== 1'b1 || beat_cnt !== '0) begin
            n_bad++;
            $display("FAIL midstream_reset got level=%0d ov=%b ready=%b beats=%0d want 0 0 1 0",
                     level, out_valid, ready, beat_cnt);
        end
        for (int i = 0; i < 2; i++) drive_cycle(1'b1, 32'h5EED_0000 + i, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 32'h5EED_0000 + i) begin
                n_bad++;
                $display("FAIL post_reset_word idx=%0d got v=%b data=%h want 1 %h",
                         i, out_valid, out_data, 32'h5EED_0000 + i);
            end
            drive_cycle(1'b0, '0, 1'b1);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || level !== '0) begin
            n_bad++;
            $display("FAIL post_reset_empty got ov=%b level=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_beat_wrap();
        int pushed = 0;
        apply_reset();
        out_ready4 = 1;
        while (pushed < 20) begin
            valid4   = 1;
            data_in4 = DATA_W'(pushed);
            if (ready4 === 1'b1) pushed++;
            @(posedge clk);
            #1;
            if (pushed == 15 || pushed == 16) begin
                n_cmp++;
                if (beat_cnt4 !== 4'(pushed % 16)) begin
                    n_bad++;
                    $display("FAIL beat_wrap_edge pushed=%0d got %0d want %0d",
                             pushed, beat_cnt4, pushed % 16);
                end
            end
        end
        valid4 = 0;
        out_ready4 = 0;
        n_cmp++;
        if (beat_cnt4 !== 4'(20 % 16)) begin
            n_bad++;
            $display("FAIL beat_wrap_20 got %0d want %0d", beat_cnt4, 20 % 16);
        end
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_fill_full();
        test_stream();
        test_random();
        test_reset_midstream();
        test_beat_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
